i2c_txn_arbiter: RTL and testbench
==================================

# i2c_txn_arbiter

- Shares the single I2C master core between two requesters: a write requester (`write_enable`/`word` path) and a read requester (`read_enable` path feeding `leds`).
- Arbitrates round-robin, issues one command per grant to the master's command port, and waits for the master's response.
- Returns a completion (done, error, read data) to the granted requester.
- Sits between the top-level control logic and the I2C master, inside `top`.

## Interface
Parameters:
- SLAVE_ADDR, 7'h50, 7-bit target address driven on every command
- TIMEOUT_CYCLES, 200000, watchdog limit in clk cycles; used only with I2C_ARB_TIMEOUT_EN

Ports (clock and reset first):
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- wr_req  in  1  write request, level
- wr_data  in  8  byte to write; captured at grant
- wr_gnt  out  1  one-cycle pulse, write request accepted
- wr_done  out  1  one-cycle pulse, write transaction finished
- wr_err  out  1  valid with wr_done; 1 = NACK or timeout
- rd_req  in  1  read request, level
- rd_gnt  out  1  one-cycle pulse, read request accepted
- rd_done  out  1  one-cycle pulse, read transaction finished
- rd_err  out  1  valid with rd_done
- rd_data  out  8  last successfully read byte; holds between reads
- m_cmd_valid  out  1  command valid to master
- m_cmd_ready  in  1  master accepts command
- m_cmd_rw  out  1  1 = read, 0 = write
- m_cmd_addr  out  7  equals SLAVE_ADDR
- m_cmd_data  out  8  write byte (don't-care for reads, driven 0)
- m_rsp_valid  in  1  one-cycle pulse, master finished (STOP sent)
- m_rsp_data  in  8  read byte, valid with m_rsp_valid
- m_rsp_nack  in  1  slave NACK seen, valid with m_rsp_valid
- m_abort  out  1  one-cycle pulse, master must release bus and issue STOP
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP (plus TOUT with the macro).
- IDLE, arbitration:
  - Only one request high: grant it.
  - Both high: grant the one not served last.
  - `last` pointer resets to "read", so write wins the first tie.
  - `last` is updated at grant.
- Grant:
  - Pulse the matching gnt.
  - Latch rw; for writes, latch wr_data into m_cmd_data.
  - Go to ISSUE.
- ISSUE: hold m_cmd_valid=1 with rw/addr/data stable until m_cmd_valid & m_cmd_ready, then go to WAIT.
- WAIT: on m_rsp_valid, capture nack; for reads, also capture m_rsp_data; go to RESP.
- RESP:
  - Pulse done on the granted side, with err = captured nack.
  - rd_data updates only on a read completion with nack=0.
  - Go to IDLE.
- Requests are levels. A requester holding req after done is re-eligible, and round-robin forces alternation when both hold.
- m_rsp_valid is ignored in IDLE and ISSUE. m_cmd_ready is ignored outside ISSUE.
- Reset mid-transaction (rst low at any time): FSM to IDLE, all outputs to 0 immediately, no done emitted. The master is responsible for its own reset.

## Timing
- Reset values: all outputs 0, rd_data=8'h00, state IDLE.
- Request seen high in IDLE at edge N:
  - gnt=1 and m_cmd_valid=1 during cycle N+1.
  - gnt drops at N+2.
- Handshake at edge H: m_cmd_valid=0 from H+1.
- m_rsp_valid at edge R: done/err (and rd_data) valid during cycle R+1; IDLE from R+2.
- Next grant can be seen at R+3 at the earliest.
- Minimum req→done: 3 cycles, when the master returns ready in ISSUE's first cycle and the response arrives the cycle after the handshake.
- The one-cycle gnt and done pulses never overlap for the same requester.

## Configuration
- Macro: I2C_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ISSUE and WAIT and clears on entry to ISSUE.
  - On reaching TIMEOUT_CYCLES, go to TOUT: pulse m_abort for one cycle, plus done with err=1 to the granted requester the same cycle, then return to IDLE.
  - rd_data is unchanged.
- Undefined:
  - No counter and no TOUT state.
  - m_abort is tied to 0.
  - ISSUE and WAIT wait indefinitely.

## Test plan
- Single write: wr_req=1 with wr_data=8'hA5, master ready immediately, response nack=0 → wr_gnt 1 pulse, m_cmd_rw=0, m_cmd_data=8'hA5, m_cmd_addr=7'h50, wr_done=1 with wr_err=0; rd_* stay 0.
- Single read: rd_req=1, response m_rsp_data=8'h3C, nack=0 → rd_done=1, rd_err=0, rd_data=8'h3C, held after rd_req drops.
- Contention: wr_req and rd_req both high from reset, held for 4 transactions → grant order write, read, write, read; busy low exactly 1 cycle between transactions.
- NACK read: rd_req with response nack=1, m_rsp_data=8'hFF → rd_done=1, rd_err=1, rd_data keeps its previous value 8'h3C.
- Backpressure/reset: m_cmd_ready held 0 for 10 cycles → command fields stable throughout; then assert rst=0 in WAIT → all outputs 0 asynchronously, no done, next request granted normally.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no m_rsp_valid → m_abort and wr_done with wr_err=1 in the same cycle, 16 cycles after ISSUE entry; FSM back in IDLE.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master between a write and a read requester.
// Optional watchdog/abort path enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
    parameter logic [6:0]  SLAVE_ADDR     = 7'h50,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_req,
    input  logic [7:0] wr_data,
    output logic       wr_gnt,
    output logic       wr_done,
    output logic       wr_err,
    input  logic       rd_req,
    output logic       rd_gnt,
    output logic       rd_done,
    output logic       rd_err,
    output logic [7:0] rd_data,
    output logic       m_cmd_valid,
    input  logic       m_cmd_ready,
    output logic       m_cmd_rw,
    output logic [6:0] m_cmd_addr,
    output logic [7:0] m_cmd_data,
    input  logic       m_rsp_valid,
    input  logic [7:0] m_rsp_data,
    input  logic       m_rsp_nack,
    output logic       m_abort,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_TOUT
    } state_e;

    state_e     state_q, state_d;
    logic       last_rd_q, last_rd_d;
    logic       rw_q, rw_d;
    logic [7:0] wdat_q, wdat_d;
    logic       nack_q, nack_d;
    logic [7:0] rdat_q, rdat_d;
    logic       wr_gnt_q, wr_gnt_d;
    logic       rd_gnt_q, rd_gnt_d;
    logic       tout;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic          expired;

    assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign tout    = (state_q == S_TOUT);

    // Watchdog: cleared while idle, counts across ISSUE and WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            cnt_q <= '0;
        end else if (state_q == S_ISSUE || state_q == S_WAIT) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
`else
    assign tout = 1'b0;
`endif

    // State and transaction context registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            last_rd_q <= 1'b1;
            rw_q      <= 1'b0;
            wdat_q    <= '0;
            nack_q    <= 1'b0;
            rdat_q    <= '0;
            wr_gnt_q  <= 1'b0;
            rd_gnt_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            rw_q      <= rw_d;
            wdat_q    <= wdat_d;
            nack_q    <= nack_d;
            rdat_q    <= rdat_d;
            wr_gnt_q  <= wr_gnt_d;
            rd_gnt_q  <= rd_gnt_d;
        end
    end

    // Arbitration, command sequencing and response capture
    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        rw_d      = rw_q;
        wdat_d    = wdat_q;
        nack_d    = nack_q;
        rdat_d    = rdat_q;
        wr_gnt_d  = 1'b0;
        rd_gnt_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (wr_req && (!rd_req || last_rd_q)) begin
                    wr_gnt_d  = 1'b1;
                    rw_d      = 1'b0;
                    wdat_d    = wr_data;
                    last_rd_d = 1'b0;
                    state_d   = S_ISSUE;
                end else if (rd_req) begin
                    rd_gnt_d  = 1'b1;
                    rw_d      = 1'b1;
                    wdat_d    = '0;
                    last_rd_d = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (m_cmd_ready) begin
                    state_d = S_WAIT;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (expired) begin
                    state_d = S_TOUT;
                end
`endif
            end
            S_WAIT: begin
                if (m_rsp_valid) begin
                    nack_d = m_rsp_nack;
                    if (rw_q && !m_rsp_nack) begin
                        rdat_d = m_rsp_data;
                    end
                    state_d = S_RESP;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (expired) begin
                    state_d = S_TOUT;
                end
`endif
            end
            S_RESP: state_d = S_IDLE;
            S_TOUT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic issue;
    logic fin;
    logic err;

    assign issue = (state_q == S_ISSUE);
    assign fin   = (state_q == S_RESP) | tout;
    assign err   = tout | nack_q;

    assign m_cmd_valid = issue;
    assign m_cmd_rw    = issue & rw_q;
    assign m_cmd_addr  = issue ? SLAVE_ADDR : 7'h00;
    assign m_cmd_data  = issue ? wdat_q : 8'h00;
    assign m_abort     = tout;

    assign wr_gnt  = wr_gnt_q;
    assign rd_gnt  = rd_gnt_q;
    assign wr_done = fin & ~rw_q;
    assign rd_done = fin & rw_q;
    assign wr_err  = wr_done & err;
    assign rd_err  = rd_done & err;
    assign rd_data = rdat_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: vector table, directed corner
// sequences and randomized transactions against a round-robin reference model.
module tb_i2c_txn_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_req, rd_req;
    logic [7:0] wr_data;
    logic       wr_gnt, wr_done, wr_err;
    logic       rd_gnt, rd_done, rd_err;
    logic [7:0] rd_data;
    logic       m_cmd_valid, m_cmd_ready, m_cmd_rw;
    logic [6:0] m_cmd_addr;
    logic [7:0] m_cmd_data;
    logic       m_rsp_valid, m_rsp_nack;
    logic [7:0] m_rsp_data;
    logic       m_abort, busy;

    int total = 0;
    int bad   = 0;

    logic       m_last_rd;
    logic [7:0] m_rdata;

    i2c_txn_arbiter #(
        .SLAVE_ADDR(7'h50),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_req(wr_req),
        .wr_data(wr_data),
        .wr_gnt(wr_gnt),
        .wr_done(wr_done),
        .wr_err(wr_err),
        .rd_req(rd_req),
        .rd_gnt(rd_gnt),
        .rd_done(rd_done),
        .rd_err(rd_err),
        .rd_data(rd_data),
        .m_cmd_valid(m_cmd_valid),
        .m_cmd_ready(m_cmd_ready),
        .m_cmd_rw(m_cmd_rw),
        .m_cmd_addr(m_cmd_addr),
        .m_cmd_data(m_cmd_data),
        .m_rsp_valid(m_rsp_valid),
        .m_rsp_data(m_rsp_data),
        .m_rsp_nack(m_rsp_nack),
        .m_abort(m_abort),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       w;
        logic       r;
        logic [7:0] wd;
        int         rdy;
        int         rsp;
        logic [7:0] rsp_d;
        logic       nk;
        logic       erw;
        logic [7:0] ecd;
        logic       eerr;
        logic [7:0] erd;
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {8'h00, wr_gnt, wr_done, wr_err, rd_gnt, rd_done, rd_err,
                m_cmd_valid, m_cmd_rw, m_cmd_addr, m_cmd_data, m_abort, busy};
    endfunction

    // One full transaction from an IDLE cycle to the IDLE cycle after done
    task automatic do_txn(input logic w, input logic r, input logic [7:0] wd,
                          input int rdy, input int rsp,
                          input logic [7:0] rsp_d, input logic nk,
                          input logic hold, input logic erw,
                          input logic [7:0] ecd, input logic eerr,
                          input logic [7:0] erd);
        wr_req  = w;
        rd_req  = r;
        wr_data = wd;
        tick();
        chk("gnt_w", wr_gnt, !erw);
        chk("gnt_r", rd_gnt, erw);
        chk("cmd_valid", m_cmd_valid, 1);
        chk("cmd_fields", {m_cmd_rw, m_cmd_addr, m_cmd_data},
            {erw, 7'h50, ecd});
        if (!hold) begin
            wr_req = 1'b0;
            rd_req = 1'b0;
        end
        wr_data = 8'($urandom);
        for (int i = 0; i < rdy; i++) begin
            m_rsp_valid = 1'($urandom);
            m_rsp_nack  = 1'($urandom);
            m_rsp_data  = 8'($urandom);
            tick();
            chk("hold_valid", m_cmd_valid, 1);
            chk("hold_fields", {m_cmd_rw, m_cmd_addr, m_cmd_data},
                {erw, 7'h50, ecd});
            chk("gnt_pulse", wr_gnt | rd_gnt, 0);
        end
        m_rsp_valid = 1'b0;
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        chk("cmd_drop", m_cmd_valid, 0);
        chk("gnt_drop", wr_gnt | rd_gnt, 0);
        for (int i = 0; i < rsp; i++) begin
            m_cmd_ready = 1'($urandom);
            tick();
            chk("wait_nodone", wr_done | rd_done, 0);
            chk("wait_busy", busy, 1);
        end
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b1;
        m_rsp_data  = rsp_d;
        m_rsp_nack  = nk;
        tick();
        m_rsp_valid = 1'b0;
        m_rsp_data  = 8'($urandom);
        m_rsp_nack  = 1'($urandom);
        chk("done_w", {wr_done, wr_err}, {!erw, !erw & eerr});
        chk("done_r", {rd_done, rd_err}, {erw, erw & eerr});
        chk("rd_data", rd_data, erd);
        chk("no_abort", m_abort, 0);
        tick();
        chk("idle_busy", busy, 0);
        chk("done_pulse", wr_done | rd_done, 0);
        chk("rd_data_hold", rd_data, erd);
    endtask

    // Reference-model driven transaction
    task automatic model_txn(input logic w, input logic r, input logic [7:0] wd,
                             input int rdy, input int rsp,
                             input logic [7:0] rsp_d, input logic nk);
        logic       erw;
        logic [7:0] erd;
        erw = (w && r) ? !m_last_rd : r;
        erd = (erw && !nk) ? rsp_d : m_rdata;
        do_txn(w, r, wd, rdy, rsp, rsp_d, nk, 1'b0, erw,
               erw ? 8'h00 : wd, nk, erd);
        m_last_rd = erw;
        m_rdata   = erd;
    endtask

    initial begin
        int seen;
        logic [1:0] v;

        rst = 1'b0;
        wr_req = 0; rd_req = 0; wr_data = 0;
        m_cmd_ready = 0; m_rsp_valid = 0; m_rsp_data = 0; m_rsp_nack = 0;
        tick();
        tick();
        chk("reset_outs", all_outs(), 0);
        chk("reset_rd_data", rd_data, 8'h00);
        rst = 1'b1;
        tick();

        tbl[0] = '{1'b1, 1'b0, 8'hA5, 0, 0, 8'h77, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 8'h12, 0, 0, 8'h3C, 1'b0, 1'b1, 8'h00, 1'b0, 8'h3C};
        tbl[2] = '{1'b0, 1'b1, 8'h34, 1, 1, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1, 8'h3C};
        tbl[3] = '{1'b1, 1'b1, 8'h5A, 2, 3, 8'h11, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h3C};
        tbl[4] = '{1'b1, 1'b1, 8'h66, 1, 1, 8'hC3, 1'b0, 1'b1, 8'h00, 1'b0, 8'hC3};
        tbl[5] = '{1'b1, 1'b0, 8'h81, 0, 2, 8'h00, 1'b1, 1'b0, 8'h81, 1'b1, 8'hC3};
        tbl[6] = '{1'b0, 1'b1, 8'h99, 3, 0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00};
        for (int i = 0; i < 7; i++) begin
            do_txn(tbl[i].w, tbl[i].r, tbl[i].wd, tbl[i].rdy, tbl[i].rsp,
                   tbl[i].rsp_d, tbl[i].nk, 1'b0, tbl[i].erw, tbl[i].ecd,
                   tbl[i].eerr, tbl[i].erd);
        end

        // Contention from reset, both requests held
        rst = 1'b0;
        tick();
        rst = 1'b1;
        do_txn(1'b1, 1'b1, 8'h21, 0, 0, 8'h55, 1'b0, 1'b1, 1'b0, 8'h21, 1'b0, 8'h00);
        do_txn(1'b1, 1'b1, 8'h22, 1, 0, 8'h9A, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h9A);
        do_txn(1'b1, 1'b1, 8'h43, 0, 1, 8'h56, 1'b1, 1'b1, 1'b0, 8'h43, 1'b1, 8'h9A);
        do_txn(1'b1, 1'b1, 8'h44, 0, 0, 8'hBC, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'hBC);
        wr_req = 1'b0;
        rd_req = 1'b0;
        tick();
        chk("contention_end", busy, 0);

        // Backpressure then reset while waiting for the response
        wr_req  = 1'b1;
        wr_data = 8'hC7;
        tick();
        chk("bp_gnt", wr_gnt, 1);
        wr_req  = 1'b0;
        wr_data = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_fields", {m_cmd_valid, m_cmd_rw, m_cmd_addr, m_cmd_data},
                {1'b1, 1'b0, 7'h50, 8'hC7});
        end
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        tick();
        tick();
        chk("bp_wait_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_outs", all_outs(), 0);
        chk("async_reset_rd_data", rd_data, 8'h00);
        tick();
        rst = 1'b1;
        m_rsp_valid = 1'b1;
        tick();
        m_rsp_valid = 1'b0;
        chk("post_reset_nodone", {wr_done, rd_done, busy}, 0);
        tick();
        chk("post_reset_idle", {wr_done, rd_done, busy}, 0);
        m_last_rd = 1'b1;
        m_rdata   = 8'h00;
        model_txn(1'b1, 1'b0, 8'h3D, 0, 0, 8'h00, 1'b0);

        // Randomized transactions against the reference model
        for (int n = 0; n < 40; n++) begin
            v = 2'($urandom_range(1, 3));
            model_txn(v[0], v[1], 8'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), 8'($urandom), 1'($urandom));
        end

`ifdef I2C_ARB_TIMEOUT_EN
        // Watchdog: no response ever arrives
        wr_req  = 1'b1;
        wr_data = 8'hE1;
        tick();
        chk("tout_gnt", wr_gnt, 1);
        wr_req = 1'b0;
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        seen = -1;
        for (int e = 2; e <= 40 && seen < 0; e++) begin
            tick();
            if (m_abort) seen = e;
        end
        chk("tout_latency", seen, 16);
        chk("tout_done", {m_abort, wr_done, wr_err, rd_done}, 4'b1110);
        tick();
        chk("tout_pulse", {m_abort, wr_done, busy}, 0);
        chk("tout_rd_data", rd_data, m_rdata);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
